// File: rtl/fetch_buffer.sv
// fetch_buffer: instruction queue between instruction memory and decode.
// Circular buffer of {address, instruction} pairs. The buffer empties in one
// cycle on a flush, and wrong-path fetches are dropped for FLUSH_SHADOW
// cycles after it.
// Optional feature macro FETCH_BUFFER_BYPASS_EN: when the buffer is empty and
// decode is not stalled, an accepted fetch goes straight to out_* in the same
// cycle instead of being written.
module fetch_buffer #(
  parameter int DEPTH        = 4,
  parameter int FLUSH_SHADOW = 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [31:0]              in_instruction,
  input  logic [31:0]              in_addr,
  output logic                     in_ready,
  input  logic                     stall,
  input  logic                     do_flush,
  output logic                     out_valid,
  output logic [31:0]              out_instruction,
  output logic [31:0]              out_addr,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [31:0] NOP = 32'h00000013;

  logic [31:0]   mem_instr [DEPTH];
  logic [31:0]   mem_addr  [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count_q;
  logic [1:0]    shadow;
  logic          overflow_q;

  logic shadow_active;
  logic full;
  logic empty;
  logic accept;
  logic bypass;
  logic pop;
  logic write;
  logic drop;

  // Decide what happens at the coming edge: pop, write, bypass or drop.
  always_comb begin
    shadow_active = (shadow != 2'd0);
    full          = (count_q == CW'(DEPTH));
    empty         = (count_q == '0);
    accept        = in_valid & ~shadow_active & ~do_flush;
    pop           = ~empty & ~stall & ~do_flush;
`ifdef FETCH_BUFFER_BYPASS_EN
    bypass        = accept & empty & ~stall;
`else
    bypass        = 1'b0;
`endif
    write         = accept & ~bypass & (~full | pop);
    drop          = accept & full & ~pop;
  end

  // Control state: pointers, occupancy, shadow window and sticky overflow.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head       <= '0;
      tail       <= '0;
      count_q    <= '0;
      shadow     <= 2'd0;
      overflow_q <= 1'b0;
    end else if (do_flush) begin
      head    <= '0;
      tail    <= '0;
      count_q <= '0;
      shadow  <= 2'(FLUSH_SHADOW);
    end else begin
      if (shadow_active) shadow <= shadow - 2'd1;
      if (pop)           head   <= head + 1'b1;
      if (write)         tail   <= tail + 1'b1;
      if (write && !pop)      count_q <= count_q + 1'b1;
      else if (pop && !write) count_q <= count_q - 1'b1;
      if (drop) overflow_q <= 1'b1;
    end
  end

  // Storage is data only; its contents are meaningless until written.
  always_ff @(posedge clock) begin
    if (write) begin
      mem_instr[tail] <= in_instruction;
      mem_addr[tail]  <= in_addr;
    end
  end

  // Head presentation: stored entry, else bypassed input, else NOP/0.
  always_comb begin
    out_valid       = ~empty | bypass;
    out_instruction = NOP;
    out_addr        = '0;
    if (!empty) begin
      out_instruction = mem_instr[head];
      out_addr        = mem_addr[head];
    end else if (bypass) begin
      out_instruction = in_instruction;
      out_addr        = in_addr;
    end
  end

  assign in_ready = (count_q <= CW'(DEPTH - 2));
  assign count    = count_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_fetch_buffer.sv
// Testbench for fetch_buffer: directed scenarios followed by a random phase,
// checked each cycle against a queue-based reference model.
module tb_fetch_buffer;

  localparam int DEPTH        = 4;
  localparam int FLUSH_SHADOW = 1;
  localparam int CW           = $clog2(DEPTH) + 1;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic [31:0]   in_instruction = '0;
  logic [31:0]   in_addr = '0;
  logic          in_ready;
  logic          stall = 1'b0;
  logic          do_flush = 1'b0;
  logic          out_valid;
  logic [31:0]   out_instruction;
  logic [31:0]   out_addr;
  logic [CW-1:0] count;
  logic          overflow;

  fetch_buffer #(.DEPTH(DEPTH), .FLUSH_SHADOW(FLUSH_SHADOW)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid),
    .in_instruction(in_instruction), .in_addr(in_addr), .in_ready(in_ready),
    .stall(stall), .do_flush(do_flush), .out_valid(out_valid),
    .out_instruction(out_instruction), .out_addr(out_addr),
    .count(count), .overflow(overflow)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] instr;
  } entry_t;

  entry_t q[$];
  int     shadow_m;
  logic   ovf_m;
  int     n_checks = 0;
  int     n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Model: does the current input go straight to the output this cycle?
  function automatic logic bypass_now();
`ifdef FETCH_BUFFER_BYPASS_EN
    return (q.size() == 0) && !stall && in_valid && (shadow_m == 0) && !do_flush;
`else
    return 1'b0;
`endif
  endfunction

  task automatic check_outputs();
    logic        ev;
    logic [31:0] ei, ea;
    ev = 1'b0; ei = 32'h00000013; ea = '0;
    if (q.size() > 0) begin
      ev = 1'b1; ei = q[0].instr; ea = q[0].addr;
    end else if (bypass_now()) begin
      ev = 1'b1; ei = in_instruction; ea = in_addr;
    end
    check("out_valid", 32'(out_valid), 32'(ev));
    check("out_instruction", out_instruction, ei);
    check("out_addr", out_addr, ea);
    check("count", 32'(count), 32'(q.size()));
    check("in_ready", 32'(in_ready), 32'(q.size() <= DEPTH - 2));
    check("overflow", 32'(overflow), 32'(ovf_m));
  endtask

  // Model: apply one clock edge using the rules of the buffer.
  task automatic model_edge();
    logic accepted, popped, byp;
    int   size_before;
    if (do_flush) begin
      q.delete();
      shadow_m = FLUSH_SHADOW;
      return;
    end
    byp         = bypass_now();
    accepted    = in_valid && (shadow_m == 0);
    size_before = q.size();
    popped      = (size_before > 0) && !stall;
    if (popped) void'(q.pop_front());
    if (accepted && !byp) begin
      if (size_before < DEPTH || popped) q.push_back('{addr: in_addr, instr: in_instruction});
      else ovf_m = 1'b1;
    end
    if (shadow_m > 0) shadow_m--;
  endtask

  task automatic step(input logic iv, input logic [31:0] ia, input logic st, input logic fl);
    @(negedge clock);
    in_valid       = iv;
    in_addr        = ia;
    in_instruction = $urandom;
    stall          = st;
    do_flush       = fl;
    #1;
    check_outputs();
    @(posedge clock);
    model_edge();
  endtask

  // Reset asserted between edges; outputs must clear without a clock edge.
  task automatic async_reset();
    @(negedge clock);
    in_valid = 1'b0; stall = 1'b0; do_flush = 1'b0;
    #2 reset = 1'b1;
    #1;
    q.delete(); shadow_m = 0; ovf_m = 1'b0;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_instruction", out_instruction, 32'h00000013);
    check("rst_out_addr", out_addr, 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_count", 32'(count), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    #1 reset = 1'b0;
  endtask

  initial begin
    logic        pend;
    logic        rdy;
    logic [31:0] a;
    shadow_m = 0;
    ovf_m    = 1'b0;

    // Power-on reset values.
    #1;
    check("por_out_valid", 32'(out_valid), 32'd0);
    check("por_out_instruction", out_instruction, 32'h00000013);
    check("por_count", 32'(count), 32'd0);
    check("por_in_ready", 32'(in_ready), 32'd1);
    @(negedge clock);
    reset = 1'b0;

    // Stream six instructions with no stall.
    for (int i = 0; i < 6; i++) step(1'b1, 32'(i * 4), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 32'd0, 1'b0, 1'b0);

    // Stall fill honouring in_ready with one-cycle fetch latency.
    pend = 1'b0;
    a    = 32'h100;
    for (int i = 0; i < 8; i++) begin
      rdy = (q.size() <= DEPTH - 2);
      step(pend, a, 1'b1, 1'b0);
      if (pend) a += 4;
      pend = rdy;
    end
    #1;
    check("fill_count", 32'(count), 32'd4);
    check("fill_overflow", 32'(overflow), 32'd0);
    check("fill_head", out_addr, 32'h100);

    // Forced write at full while stalled.
    step(1'b1, 32'h200, 1'b1, 1'b0);
    #1;
    check("ovf_count", 32'(count), 32'd4);
    check("ovf_flag", 32'(overflow), 32'd1);

    // Push and pop together at full, across the pointer wrap.
    for (int i = 0; i < 6; i++) step(1'b1, 32'h300 + 32'(i * 4), 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b0, 32'd0, 1'b0, 1'b0);

    // Flush with three buffered entries and wrong-path arrivals.
    for (int i = 0; i < 3; i++) step(1'b1, 32'h20 + 32'(i * 4), 1'b1, 1'b0);
    step(1'b1, 32'h3c, 1'b1, 1'b1);
    step(1'b1, 32'h40, 1'b0, 1'b0);
    step(1'b1, 32'h80, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 32'd0, 1'b0, 1'b0);

    // Asynchronous reset with two entries held, then resume streaming.
    step(1'b1, 32'h500, 1'b1, 1'b0);
    step(1'b1, 32'h504, 1'b1, 1'b0);
    async_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 32'h600 + 32'(i * 4), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 32'd0, 1'b0, 1'b0);

    // Random traffic including stalls, flushes and overflow.
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 99) < 70), $urandom & 32'hFFFF_FFFC,
           1'($urandom_range(0, 99) < 35), 1'($urandom_range(0, 99) < 6));
      if (i == 200) async_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
